// File: rtl/svm_window_sequencer.sv
// svm_window_sequencer
//
// Steps one HOG detection window through the per-block SVM accumulator bank.
// Normalized block-descriptor values stream in and are forwarded, one cycle
// later, to the accumulator selected by acc_block_idx. Each block's
// accumulator is seeded with the previous block's result, and block 0 is
// seeded with BIAS. After the last block the window score and the detect
// decision are strobed for one cycle.
//
// Optional feature: define SVM_SEQ_WATCHDOG_EN to enable the result watchdog.
// With it, a missing accumulator result aborts the window after
// RESULT_TIMEOUT cycles and pulses error and acc_reset for one cycle.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     descriptor value handshake
//   in_data               unsigned descriptor value
//   acc_block_idx         selected accumulator (also drives the result mux)
//   acc_value_de/value    value strobe and data to the selected accumulator
//   acc_init_de/init      init strobe and signed seed value
//   acc_reset             accumulator bank reset (reset or watchdog abort)
//   acc_result_de/result  muxed accumulator output strobe and signed value
//   score_valid/score     one-cycle window score strobe, score held between
//   detect                score > THRESHOLD, valid with score_valid
//   error                 watchdog timeout pulse
module svm_window_sequencer #(
  parameter int VECTOR_LENGTH = 36,
  parameter int VECTOR_WIDTH = 12,
  parameter int ACC_WIDTH = 44,
  parameter int NUM_BLOCKS = 105,
  parameter logic signed [ACC_WIDTH-1:0] BIAS = '0,
  parameter logic signed [ACC_WIDTH-1:0] THRESHOLD = '0,
  parameter int RESULT_TIMEOUT = 32,
  localparam int IDXW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [VECTOR_WIDTH-1:0]     in_data,
  output logic [IDXW-1:0]             acc_block_idx,
  output logic                        acc_value_de,
  output logic [VECTOR_WIDTH-1:0]     acc_value,
  output logic                        acc_init_de,
  output logic [ACC_WIDTH-1:0]        acc_init,
  output logic                        acc_reset,
  input  logic                        acc_result_de,
  input  logic [ACC_WIDTH-1:0]        acc_result,
  output logic                        score_valid,
  output logic [ACC_WIDTH-1:0]        score,
  output logic                        detect,
  output logic                        error
);

  localparam int BEATW = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;

  localparam logic [1:0] LOAD_INIT   = 2'd0;
  localparam logic [1:0] STREAM      = 2'd1;
  localparam logic [1:0] WAIT_RESULT = 2'd2;
  localparam logic [1:0] DONE        = 2'd3;

  logic [1:0]                  r_state;
  logic [IDXW-1:0]             r_blk;
  logic [BEATW-1:0]            r_beat;
  logic signed [ACC_WIDTH-1:0] r_init;
  logic signed [ACC_WIDTH-1:0] r_score;
  logic                        r_valueDe;
  logic [VECTOR_WIDTH-1:0]     r_value;

  logic w_handshake;
  logic w_lastBlock;
  logic w_lastBeat;
  logic w_timeout;

  assign w_handshake = in_valid && (r_state == STREAM);
  assign w_lastBlock = (r_blk == IDXW'(NUM_BLOCKS - 1));
  assign w_lastBeat  = (r_beat == BEATW'(VECTOR_LENGTH - 1));

`ifdef SVM_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(RESULT_TIMEOUT + 1);

  logic [WDW-1:0] r_wdCount;

  // The counter sits at zero outside WAIT_RESULT, so it reads k on the k-th
  // cycle after entry. A result on the timeout cycle takes priority.
  assign w_timeout = (r_state == WAIT_RESULT) && !acc_result_de &&
                     (r_wdCount == WDW'(RESULT_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset || (r_state != WAIT_RESULT)) begin
      r_wdCount <= '0;
    end else begin
      r_wdCount <= r_wdCount + 1'b1;
    end
  end

  assign error     = w_timeout && !reset;
  assign acc_reset = reset || w_timeout;
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
  assign acc_reset = reset;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= LOAD_INIT;
      r_blk     <= '0;
      r_beat    <= '0;
      r_init    <= BIAS;
      r_score   <= '0;
      r_valueDe <= 1'b0;
      r_value   <= '0;
    end else begin
      // Values are forwarded one cycle after their handshake.
      r_valueDe <= w_handshake;
      if (w_handshake) begin
        r_value <= in_data;
      end

      case (r_state)
        LOAD_INIT: begin
          r_beat  <= '0;
          r_state <= STREAM;
        end
        STREAM: begin
          if (w_handshake) begin
            r_beat <= r_beat + 1'b1;
            if (w_lastBeat) begin
              r_state <= WAIT_RESULT;
            end
          end
        end
        WAIT_RESULT: begin
          if (acc_result_de) begin
            if (!w_lastBlock) begin
              // Chain the partial sum into the next block's seed.
              r_init  <= acc_result;
              r_blk   <= r_blk + 1'b1;
              r_state <= LOAD_INIT;
            end else begin
              r_score <= acc_result;
              r_state <= DONE;
            end
          end else if (w_timeout) begin
            r_blk   <= '0;
            r_init  <= BIAS;
            r_state <= LOAD_INIT;
          end
        end
        DONE: begin
          r_blk   <= '0;
          r_init  <= BIAS;
          r_state <= LOAD_INIT;
        end
        default: begin
          r_state <= LOAD_INIT;
        end
      endcase
    end
  end

  // Reset is synchronous, so every output is also masked by reset directly
  // to keep the bank quiet from the first cycle reset is seen.
  assign in_ready      = !reset && (r_state == STREAM);
  assign acc_init_de   = !reset && (r_state == LOAD_INIT);
  assign acc_init      = acc_init_de ? r_init : '0;
  assign acc_value_de  = !reset && r_valueDe;
  assign acc_value     = reset ? '0 : r_value;
  assign acc_block_idx = reset ? '0 : r_blk;
  assign score_valid   = !reset && (r_state == DONE);
  assign score         = reset ? '0 : r_score;
  assign detect        = score_valid && (r_score > THRESHOLD);

endmodule

// File: tb/tb_svm_window_sequencer.sv
// tb_svm_window_sequencer
//
// Self-checking bench for svm_window_sequencer (NUM_BLOCKS=4, BIAS=10).
// Two instances share all inputs: THRESHOLD=100 and THRESHOLD=-6; only the
// detect output differs between them. A mock accumulator answers 6 cycles
// after the last value strobe of each block with init + sum(values), or a
// forced value for the final block. Expected inits, value order, scores and
// detects come from a window-level model built from the stimulus itself.
// Build with SVM_SEQ_WATCHDOG_EN defined to exercise the watchdog path.
module tb_svm_window_sequencer;

  localparam int VL = 36;
  localparam int VW = 12;
  localparam int AW = 44;
  localparam int NB = 4;
  localparam int TO = 32;
  localparam longint BIAS_L = 10;
  localparam longint THR_L = 100;
  localparam longint THR2_L = -6;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [VW-1:0] in_data;
  logic acc_result_de;
  logic [AW-1:0] acc_result;

  logic in_ready, acc_value_de, acc_init_de, acc_reset, score_valid, detect, error;
  logic [1:0] acc_block_idx;
  logic [VW-1:0] acc_value;
  logic [AW-1:0] acc_init, score;

  logic in_ready_2, acc_value_de_2, acc_init_de_2, acc_reset_2, score_valid_2, detect_2, error_2;
  logic [1:0] acc_block_idx_2;
  logic [VW-1:0] acc_value_2;
  logic [AW-1:0] acc_init_2, score_2;

  svm_window_sequencer #(
    .VECTOR_LENGTH(VL), .VECTOR_WIDTH(VW), .ACC_WIDTH(AW), .NUM_BLOCKS(NB),
    .BIAS(AW'(BIAS_L)), .THRESHOLD(AW'(THR_L)), .RESULT_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_block_idx(acc_block_idx), .acc_value_de(acc_value_de), .acc_value(acc_value),
    .acc_init_de(acc_init_de), .acc_init(acc_init), .acc_reset(acc_reset),
    .acc_result_de(acc_result_de), .acc_result(acc_result),
    .score_valid(score_valid), .score(score), .detect(detect), .error(error)
  );

  svm_window_sequencer #(
    .VECTOR_LENGTH(VL), .VECTOR_WIDTH(VW), .ACC_WIDTH(AW), .NUM_BLOCKS(NB),
    .BIAS(AW'(BIAS_L)), .THRESHOLD(AW'(THR2_L)), .RESULT_TIMEOUT(TO)
  ) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_2), .in_data(in_data),
    .acc_block_idx(acc_block_idx_2), .acc_value_de(acc_value_de_2), .acc_value(acc_value_2),
    .acc_init_de(acc_init_de_2), .acc_init(acc_init_2), .acc_reset(acc_reset_2),
    .acc_result_de(acc_result_de), .acc_result(acc_result),
    .score_valid(score_valid_2), .score(score_2), .detect(detect_2), .error(error_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     pattern;   // 0: block b carries value b+1, 1: random values
    int     gapMode;   // 0: gapless, 1: toggle, 2: random gaps
    bit     spur;      // inject a stray result strobe mid-stream
    bit     ovrEn;     // mock forces the final block result
    longint ovrVal;
    bit     useModel;  // expected score from model instead of table
    longint score;
    bit     det;
    bit     det2;
  } winVec_t;

  winVec_t tbl[9];

  int nChecks = 0;
  int nFails = 0;
  int cyc = 0;

  longint expInitQ[$];
  int     expIdxQ[$];
  int     expValQ[$];
  longint expScoreQ[$];
  bit     expDetQ[$];
  bit     expDet2Q[$];
  int     sendQ[$];

  bit rstReq;
  int gapMode;
  bit spurEn, spurDone;
  int sentInBlock, blocksDone;
  bit waitingResult;
  bit expErr;
  int curIdx;
  longint lastScore;

  longint mockAcc, mockResult, ovrVal;
  int mockCount, mockDelay, mockBlk;
  bit mockHang, ovrEn;

  bit scoreSeen;
  int lastResultCycle, scoreCycle, lastInitCycle;
  bit firstValPending;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic checkOutput();
    if (reset) begin
      checkVal("acc_reset during reset", acc_reset, 1);
      checkVal("strobes during reset",
               {in_ready, acc_init_de, acc_value_de, score_valid, detect, error}, 0);
      checkVal("data outputs during reset",
               {acc_block_idx, acc_value, acc_init, score}, 0);
      return;
    end
    checkVal("error", error, expErr);
    checkVal("acc_reset", acc_reset, expErr);
    if (waitingResult) checkVal("in_ready in WAIT_RESULT", in_ready, 0);
    if (scoreCycle == cyc - 1) checkVal("init after score_valid", acc_init_de, 1);

    if (acc_init_de) begin
      if (expInitQ.size() == 0) begin
        failNow("unexpected acc_init_de");
      end else begin
        checkVal("acc_init", longint'($signed(acc_init)), expInitQ.pop_front());
        curIdx = expIdxQ.pop_front();
      end
      mockAcc = longint'($signed(acc_init));
      mockCount = 0;
      lastInitCycle = cyc;
      firstValPending = 1;
    end
    checkVal("acc_block_idx", acc_block_idx, curIdx);

    if (acc_value_de) begin
      if (expValQ.size() == 0) begin
        failNow("extra acc_value_de");
      end else begin
        checkVal("acc_value order", acc_value, expValQ.pop_front());
      end
      if (firstValPending && gapMode == 0) checkVal("init to first value cycles", cyc - lastInitCycle, 2);
      firstValPending = 0;
      mockAcc += acc_value;
      mockCount++;
      if (mockCount == VL) begin
        mockCount = 0;
        if (!mockHang) begin
          mockDelay = 6;
          mockResult = (ovrEn && mockBlk == NB - 1) ? ovrVal : mockAcc;
        end
        mockBlk++;
      end
    end

    if (score_valid) begin
      scoreSeen = 1;
      scoreCycle = cyc;
      checkVal("score_valid after last result", cyc - lastResultCycle, 1);
      if (expScoreQ.size() == 0) begin
        failNow("unexpected score_valid");
      end else begin
        lastScore = expScoreQ.pop_front();
        checkVal("score", longint'($signed(score)), lastScore);
        checkVal("detect THRESHOLD=100", detect, expDetQ.pop_front());
        checkVal("detect THRESHOLD=-6", detect_2, expDet2Q.pop_front());
      end
    end else begin
      checkVal("detect outside DONE", {detect, detect_2}, 0);
      checkVal("score holds", longint'($signed(score)), lastScore);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 ns later, account at posedge.
  task automatic applyStimulus();
    bit hs, resDrv;
    @(negedge clk);
    cyc++;
    reset = rstReq;
    in_valid = 1'b0;
    if (sendQ.size() > 0 && !rstReq) begin
      case (gapMode)
        0: in_valid = 1'b1;
        1: in_valid = cyc[0];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = VW'(sendQ[0]);
    end
    acc_result_de = 1'b0;
    acc_result = '0;
    resDrv = 0;
    if (mockDelay == 1) begin
      acc_result_de = 1'b1;
      acc_result = AW'(mockResult);
      resDrv = 1;
    end else if (spurEn && !spurDone && sentInBlock == 10) begin
      acc_result_de = 1'b1;
      acc_result = AW'({$urandom, $urandom});
      spurDone = 1;
    end
    if (mockDelay > 0) mockDelay--;
    #1;
    checkOutput();
    hs = in_valid && in_ready;
    @(posedge clk);
    if (hs) begin
      void'(sendQ.pop_front());
      sentInBlock++;
      if (sentInBlock == VL) waitingResult = 1;
    end
    if (resDrv) begin
      waitingResult = 0;
      lastResultCycle = cyc;
      sentInBlock = 0;
      spurDone = 0;
      blocksDone++;
    end
  endtask

  task automatic doReset();
    rstReq = 1;
    repeat (2) applyStimulus();
    rstReq = 0;
    sendQ.delete(); expValQ.delete(); expInitQ.delete(); expIdxQ.delete();
    expScoreQ.delete(); expDetQ.delete(); expDet2Q.delete();
    mockDelay = 0; mockCount = 0; mockBlk = 0; mockHang = 0;
    sentInBlock = 0; blocksDone = 0; waitingResult = 0; spurDone = 0; spurEn = 0;
    firstValPending = 0; curIdx = 0; lastScore = 0; expErr = 0;
    expInitQ.push_back(BIAS_L);
    expIdxQ.push_back(0);
  endtask

  // Builds the window-level expectations, then clocks until the score
  // strobe, or until the abort point (block abortBlk, beat 20) if given.
  task automatic runWindow(input winVec_t v, input int abortBlk);
    longint chain, expScore;
    int val;
    chain = BIAS_L;
    mockBlk = 0; blocksDone = 0;
    gapMode = v.gapMode; spurEn = v.spur; ovrEn = v.ovrEn; ovrVal = v.ovrVal;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < VL; k++) begin
        val = (v.pattern == 0) ? b + 1 : int'($urandom_range(0, 4095));
        sendQ.push_back(val);
        expValQ.push_back(val);
        chain += val;
      end
      if (b < NB - 1) begin
        expInitQ.push_back(chain);
        expIdxQ.push_back(b + 1);
      end
    end
    expScore = v.ovrEn ? v.ovrVal : chain;
    if (v.useModel) begin
      expScoreQ.push_back(expScore);
      expDetQ.push_back(expScore > THR_L);
      expDet2Q.push_back(expScore > THR2_L);
    end else begin
      expScoreQ.push_back(v.score);
      expDetQ.push_back(v.det);
      expDet2Q.push_back(v.det2);
    end
    expInitQ.push_back(BIAS_L);
    expIdxQ.push_back(0);
    scoreSeen = 0;
    for (int t = 0; t < NB * 300; t++) begin
      if (scoreSeen) break;
      if (abortBlk >= 0 && blocksDone == abortBlk && sentInBlock == 20) break;
      applyStimulus();
    end
    if (abortBlk < 0 && !scoreSeen) failNow("window timeout waiting for score_valid");
    if (abortBlk >= 0) begin
      checkVal("abort point reached", {blocksDone == abortBlk, sentInBlock == 20}, 2'b11);
      checkVal("no score before abort", scoreSeen, 0);
    end
  endtask

  initial begin
    reset = 1'b1; rstReq = 1; in_valid = 1'b0; in_data = '0;
    acc_result_de = 1'b0; acc_result = '0;
    expErr = 0; scoreCycle = -10; lastResultCycle = -10; lastInitCycle = -10;
    mockHang = 0; ovrEn = 0; spurEn = 0; gapMode = 0;

    // Block b carries VL copies of b+1: inits 10, 46, 118, 226; score 370.
    tbl[0] = '{0, 0, 0, 0, 0,   0, 370, 1, 1};
    tbl[1] = '{0, 1, 1, 0, 0,   0, 370, 1, 1};
    tbl[2] = '{0, 0, 0, 1, -5,  0, -5,  0, 1};
    tbl[3] = '{0, 0, 0, 1, -7,  0, -7,  0, 0};
    tbl[4] = '{0, 2, 0, 1, 100, 0, 100, 0, 1};
    tbl[5] = '{0, 0, 0, 1, 101, 0, 101, 1, 1};
    tbl[6] = '{1, 2, 1, 0, 0,   1, 0,   0, 0};
    tbl[7] = '{1, 0, 0, 1, -6,  0, -6,  0, 0};
    tbl[8] = '{1, 1, 0, 0, 0,   1, 0,   0, 0};

    doReset();
    for (int i = 0; i < 9; i++) runWindow(tbl[i], -1);

    // Reset in the middle of block 3, then a clean window must follow.
    doReset();
    runWindow(tbl[1], 3);
    doReset();
    runWindow(tbl[0], -1);

    // The mock never answers block 0.
    doReset();
    mockHang = 1; gapMode = 0; spurEn = 0; ovrEn = 0;
    for (int k = 0; k < VL; k++) begin
      sendQ.push_back(3);
      expValQ.push_back(3);
    end
    for (int t = 0; t < 200; t++) begin
      if (waitingResult) break;
      applyStimulus();
    end
    checkVal("hang block fully streamed", waitingResult, 1);
`ifdef SVM_SEQ_WATCHDOG_EN
    repeat (TO) applyStimulus();
    expErr = 1;
    applyStimulus();
    expErr = 0;
    mockHang = 0; waitingResult = 0; sentInBlock = 0; mockBlk = 0;
    applyStimulus();
    checkVal("LOAD_INIT right after watchdog", lastInitCycle, cyc);
`else
    repeat (TO * 2) applyStimulus();
    checkVal("still waiting without watchdog", waitingResult, 1);
`endif
    doReset();
    runWindow(tbl[5], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
